sequence_ctrl: RTL and testbench

Stores the Simon colour sequence and serves it to two consumers: lamp playback and player-move checking. Sits beside the game FSM. It consumes the FSM's load_colour, rst_seedgen (as clear), check_round and flash_clk. It returns the registered move verdict `result` and the one-hot lamp drive. It owns the sequence length, write pointer and read-index arbitration.

---
 rtl/sequence_ctrl_pkg.sv | 26 ++
 rtl/sequence_ctrl_seq_mem.sv | 24 ++
 rtl/sequence_ctrl.sv | 105 ++++++++++
 tb/tb_sequence_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/sequence_ctrl_pkg.sv
// Shared types and constants for the Simon sequence store: state enum,
// sizing constants and the colour-to-lamp one-hot decode.
package sequence_ctrl_pkg;

  localparam int MAX_ROUNDS  = 32;
  localparam int COLOUR_W    = 2;
  localparam int NUM_COLOURS = 4;
  localparam int LEN_W       = 6;
  localparam int PTR_W       = 5;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_ROUNDS);

  typedef enum logic [1:0] {
    EMPTY,
    BUILD,
    FULL
  } seq_state_t;

  function automatic logic [NUM_COLOURS-1:0] onehot_colour(input logic [COLOUR_W-1:0] colour);
    logic [NUM_COLOURS-1:0] lamp_vec;
    lamp_vec         = '0;
    lamp_vec[colour] = 1'b1;
    return lamp_vec;
  endfunction

endpackage

// File: rtl/sequence_ctrl_seq_mem.sv
// Colour storage: 32 x 2-bit register file, one synchronous write port and
// one combinational read port. Contents are not reset.
module seq_mem
  import sequence_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                wr_en,
  input  logic [PTR_W-1:0]    wr_addr,
  input  logic [COLOUR_W-1:0] wr_data,
  input  logic [PTR_W-1:0]    rd_addr,
  output logic [COLOUR_W-1:0] rd_data
);

  logic [COLOUR_W-1:0] mem_q [MAX_ROUNDS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sequence_ctrl.sv
// Simon sequence store: appends colours from the game FSM and serves the
// entry selected by check_round to the lamp driver and the move checker.
module sequence_ctrl
  import sequence_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   load_colour,
  input  logic [COLOUR_W-1:0]    rng_colour,
  input  logic [LEN_W-1:0]       check_round,
  input  logic                   flash_clk,
  input  logic [NUM_COLOURS-1:0] player_input,
  output logic                   result,
  output logic [NUM_COLOURS-1:0] lamp,
  output logic [LEN_W-1:0]       seq_len,
  output logic                   full,
  output logic                   overflow
);

  seq_state_t             state_q, state_d;
  logic [LEN_W-1:0]       seq_len_q, seq_len_d;
  logic                   overflow_q, overflow_d;
  logic [NUM_COLOURS-1:0] lamp_q, lamp_d;
  logic                   result_q, result_d;

  logic                   wr_en;
  logic [PTR_W-1:0]       rd_addr;
  logic [COLOUR_W-1:0]    rd_colour;
  logic                   sel_valid;
  logic [NUM_COLOURS-1:0] expected;

  seq_mem u_seq_mem (
    .clk     (clk),
    .wr_en   (wr_en && !reset),
    .wr_addr (seq_len_q[PTR_W-1:0]),
    .wr_data (rng_colour),
    .rd_addr (rd_addr),
    .rd_data (rd_colour)
  );

  // check_round counts down from seq_len, so the entry index is the difference
  assign rd_addr   = PTR_W'(seq_len_q - check_round);
  assign sel_valid = (check_round != '0) && (check_round <= seq_len_q);
  assign expected  = sel_valid ? onehot_colour(rd_colour) : '0;

  always_comb begin
    state_d    = state_q;
    seq_len_d  = seq_len_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
    lamp_d     = flash_clk ? expected : '0;
    result_d   = sel_valid && (player_input == expected);

    if (clear) begin
      state_d    = EMPTY;
      seq_len_d  = '0;
      overflow_d = 1'b0;
    end else if (load_colour) begin
      unique case (state_q)
        EMPTY: begin
          wr_en     = 1'b1;
          seq_len_d = LEN_W'(1);
          state_d   = BUILD;
        end
        BUILD: begin
          wr_en     = 1'b1;
          seq_len_d = seq_len_q + LEN_W'(1);
          if (seq_len_d == MAX_LEN) begin
            state_d = FULL;
          end
        end
        FULL: begin
          overflow_d = 1'b1;
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      seq_len_q  <= '0;
      overflow_q <= 1'b0;
      lamp_q     <= '0;
      result_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      seq_len_q  <= seq_len_d;
      overflow_q <= overflow_d;
      lamp_q     <= lamp_d;
      result_q   <= result_d;
    end
  end

  assign result   = result_q;
  assign lamp     = lamp_q;
  assign seq_len  = seq_len_q;
  assign full     = (seq_len_q == MAX_LEN);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_sequence_ctrl.sv
// Self-checking bench for sequence_ctrl: table-driven vectors plus
// hand-written multi-cycle sequences, expectations queued per driven cycle.
module tb_sequence_ctrl;
  import sequence_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic       load_colour;
  logic [1:0] rng_colour;
  logic [5:0] check_round;
  logic       flash_clk;
  logic [3:0] player_input;
  logic       result;
  logic [3:0] lamp;
  logic [5:0] seq_len;
  logic       full;
  logic       overflow;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic       rst;
    logic       clr;
    logic       ld;
    logic [1:0] col;
    logic [5:0] cr;
    logic       fl;
    logic [3:0] pi;
    logic       exp_res;
    logic [3:0] exp_lamp;
    logic [5:0] exp_len;
    logic       exp_full;
    logic       exp_ovf;
  } vec_t;

  typedef struct {
    string      name;
    logic       res;
    logic [3:0] lamp;
    logic [5:0] len;
    logic       full;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[13];

  sequence_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .load_colour  (load_colour),
    .rng_colour   (rng_colour),
    .check_round  (check_round),
    .flash_clk    (flash_clk),
    .player_input (player_input),
    .result       (result),
    .lamp         (lamp),
    .seq_len      (seq_len),
    .full         (full),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, input logic clr, input logic ld,
                              input logic [1:0] col, input logic [5:0] cr,
                              input logic fl, input logic [3:0] pi,
                              input logic er, input logic [3:0] el,
                              input logic [5:0] elen, input logic ef,
                              input logic eo);
    vec_t v;
    v.rst = rst; v.clr = clr; v.ld = ld; v.col = col; v.cr = cr;
    v.fl = fl; v.pi = pi; v.exp_res = er; v.exp_lamp = el;
    v.exp_len = elen; v.exp_full = ef; v.exp_ovf = eo;
    return v;
  endfunction

  task automatic checkField(input string name, input string field,
                            input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s.%s: got %0h, expected %0h", name, field, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string name);
    exp_t e;
    @(negedge clk);
    reset        = v.rst;
    clear        = v.clr;
    load_colour  = v.ld;
    rng_colour   = v.col;
    check_round  = v.cr;
    flash_clk    = v.fl;
    player_input = v.pi;
    e.name = name; e.res = v.exp_res; e.lamp = v.exp_lamp;
    e.len = v.exp_len; e.full = v.exp_full; e.ovf = v.exp_ovf;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    @(posedge clk);
    #1;
    tests_run++;
    if (sb.size() == 0) begin
      tests_failed++;
      $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
    end else begin
      tests_run--;
      e = sb.pop_front();
      checkField(e.name, "result",   32'(result),   32'(e.res));
      checkField(e.name, "lamp",     32'(lamp),     32'(e.lamp));
      checkField(e.name, "seq_len",  32'(seq_len),  32'(e.len));
      checkField(e.name, "full",     32'(full),     32'(e.full));
      checkField(e.name, "overflow", 32'(overflow), 32'(e.ovf));
    end
  endtask

  task automatic step(input vec_t v, input string name);
    applyStimulus(v, name);
    checkOutput();
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; load_colour = 1'b0; rng_colour = '0;
    check_round = '0; flash_clk = 1'b0; player_input = '0;

    // Stored sequence {2,0,3}: entry0=2 (lamp 0100), entry1=0 (0001), entry2=3 (1000)
    tbl[0]  = mk(0,0,1,2'd2,6'd0,0,4'b0000, 0,4'b0000,6'd1,0,0);
    tbl[1]  = mk(0,0,1,2'd0,6'd0,0,4'b0000, 0,4'b0000,6'd2,0,0);
    tbl[2]  = mk(0,0,1,2'd3,6'd0,0,4'b0000, 0,4'b0000,6'd3,0,0);
    tbl[3]  = mk(0,0,0,2'd0,6'd3,1,4'b0000, 0,4'b0100,6'd3,0,0);
    tbl[4]  = mk(0,0,0,2'd0,6'd1,1,4'b0000, 0,4'b1000,6'd3,0,0);
    tbl[5]  = mk(0,0,0,2'd0,6'd1,0,4'b0000, 0,4'b0000,6'd3,0,0);
    tbl[6]  = mk(0,0,0,2'd0,6'd2,0,4'b0001, 1,4'b0000,6'd3,0,0);
    tbl[7]  = mk(0,0,0,2'd0,6'd2,0,4'b0010, 0,4'b0000,6'd3,0,0);
    tbl[8]  = mk(0,0,0,2'd0,6'd2,0,4'b0011, 0,4'b0000,6'd3,0,0);
    tbl[9]  = mk(0,0,0,2'd0,6'd4,0,4'b0001, 0,4'b0000,6'd3,0,0);
    tbl[10] = mk(0,0,0,2'd0,6'd2,1,4'b0001, 1,4'b0001,6'd3,0,0);
    tbl[11] = mk(0,0,0,2'd0,6'd0,1,4'b0001, 0,4'b0000,6'd3,0,0);
    tbl[12] = mk(0,0,0,2'd0,6'd3,0,4'b0100, 1,4'b0000,6'd3,0,0);

    step(mk(1,0,0,2'd0,6'd0,0,4'b0000, 0,4'b0000,6'd0,0,0), "reset");
    step(mk(1,0,0,2'd0,6'd0,0,4'b0000, 0,4'b0000,6'd0,0,0), "reset_hold");

    for (int i = 0; i < 13; i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // Clear coinciding with a load drops the write and returns to EMPTY
    step(mk(0,1,0,2'd0,6'd0,0,4'b0000, 0,4'b0000,6'd0,0,0), "clr_a");
    for (int i = 0; i < 5; i++) begin
      step(mk(0,0,1,2'd1,6'd0,0,4'b0000, 0,4'b0000,6'(i+1),0,0), $sformatf("fill5_%0d", i));
    end
    step(mk(0,1,1,2'd2,6'd0,0,4'b0000, 0,4'b0000,6'd0,0,0), "clr_and_load");
    step(mk(0,0,1,2'd3,6'd0,0,4'b0000, 0,4'b0000,6'd1,0,0), "load_after_clr");
    step(mk(0,0,0,2'd0,6'd1,1,4'b1000, 1,4'b1000,6'd1,0,0), "entry0_after_clr");

    // Fill to capacity with colour i%4, then overflow
    step(mk(0,1,0,2'd0,6'd0,0,4'b0000, 0,4'b0000,6'd0,0,0), "clr_b");
    for (int i = 0; i < 32; i++) begin
      step(mk(0,0,1,2'(i % 4),6'd0,0,4'b0000, 0,4'b0000,6'(i+1),(i == 31),0),
           $sformatf("fill32_%0d", i));
    end
    step(mk(0,0,1,2'd3,6'd0,0,4'b0000, 0,4'b0000,6'd32,1,1), "load_when_full");
    step(mk(0,0,0,2'd0,6'd32,1,4'b0001, 1,4'b0001,6'd32,1,1), "entry0_kept");
    step(mk(0,0,0,2'd0,6'd1,1,4'b1000, 1,4'b1000,6'd32,1,1), "entry31");
    step(mk(0,0,0,2'd0,6'd33,1,4'b0001, 0,4'b0000,6'd32,1,1), "cr_beyond_len");
    step(mk(0,1,0,2'd0,6'd0,0,4'b0000, 0,4'b0000,6'd0,0,0), "clr_full");

    // Reset in the middle of lamp playback
    for (int i = 0; i < 7; i++) begin
      step(mk(0,0,1,2'(i % 4),6'd0,0,4'b0000, 0,4'b0000,6'(i+1),0,0), $sformatf("fill7_%0d", i));
    end
    step(mk(0,0,0,2'd0,6'd1,1,4'b0100, 1,4'b0100,6'd7,0,0), "flash_len7");
    step(mk(1,0,0,2'd0,6'd1,1,4'b0100, 0,4'b0000,6'd0,0,0), "reset_mid");
    step(mk(0,0,0,2'd0,6'd1,1,4'b0100, 0,4'b0000,6'd0,0,0), "after_reset");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
